// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, colour constants and frame-size helpers for the
// vga_timing_pipe display path.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_CLK_DIV  = 4;
    localparam int DEF_COLOR_W  = 12;
    localparam int DEF_BLINK_FRAMES = 30;

    localparam logic [DEF_COLOR_W-1:0] COLOR_BLACK  = 12'h000;
    localparam logic [DEF_COLOR_W-1:0] COLOR_WHITE  = 12'hFFF;
    localparam logic [DEF_COLOR_W-1:0] COLOR_BORDER = 12'hFFF;

    function automatic int h_total(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Pixel-clock divider, horizontal/vertical counters and the raw (unregistered)
// sync and video-enable decode for one VGA mode.
module vga_sync_counter
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int CLK_DIV  = DEF_CLK_DIV
) (
    input  logic        reloj_nexys,
    input  logic        reset_total,
    output logic        pixel_tick,
    output logic [10:0] h_cnt,
    output logic [10:0] v_cnt,
    output logic        h_last,
    output logic        v_last,
    output logic        video_raw,
    output logic        hsync_raw,
    output logic        vsync_raw
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [10:0] H_MAX      = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_MAX      = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT      = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [10:0] h_cnt_reg;
    logic [10:0] v_cnt_reg;

    // A divide-by-one mode has no divider state at all: every clock is a pixel.
    generate
        if (CLK_DIV == 1) begin : g_no_div
            assign pixel_tick = 1'b1;
        end else begin : g_div
            localparam int DIV_W = $clog2(CLK_DIV);
            localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

            logic [DIV_W-1:0] div_reg;

            always_ff @(posedge reloj_nexys or negedge reset_total) begin
                if (!reset_total) begin
                    div_reg <= '0;
                end else if (div_reg == DIV_MAX) begin
                    div_reg <= '0;
                end else begin
                    div_reg <= div_reg + 1'b1;
                end
            end

            assign pixel_tick = (div_reg == DIV_MAX);
        end
    endgenerate

    assign h_last = (h_cnt_reg == H_MAX);
    assign v_last = (v_cnt_reg == V_MAX);

    always_ff @(posedge reloj_nexys or negedge reset_total) begin
        if (!reset_total) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else if (pixel_tick) begin
            if (h_last) begin
                h_cnt_reg <= '0;
                v_cnt_reg <= v_last ? 11'd0 : v_cnt_reg + 11'd1;
            end else begin
                h_cnt_reg <= h_cnt_reg + 11'd1;
            end
        end
    end

    assign h_cnt     = h_cnt_reg;
    assign v_cnt     = v_cnt_reg;
    assign video_raw = (h_cnt_reg < H_ACT) && (v_cnt_reg < V_ACT);
    assign hsync_raw = (h_cnt_reg >= HS_START) && (h_cnt_reg <= HS_END);
    assign vsync_raw = (v_cnt_reg >= VS_START) && (v_cnt_reg <= VS_END);

endmodule

// File: rtl/vga_timing_pipe.sv
// VGA timing and aligned output stage: colour, syncs and video_on leave on the
// same pixel, plus line/frame strobes and a frame-based blink flag.
// Optional compile-time macro VGA_BORDER_EN forces a one-pixel all-ones border.
module vga_timing_pipe
    import vga_pkg::*;
#(
    parameter int H_ACTIVE     = DEF_H_ACTIVE,
    parameter int H_FP         = DEF_H_FP,
    parameter int H_SYNC       = DEF_H_SYNC,
    parameter int H_BP         = DEF_H_BP,
    parameter int V_ACTIVE     = DEF_V_ACTIVE,
    parameter int V_FP         = DEF_V_FP,
    parameter int V_SYNC       = DEF_V_SYNC,
    parameter int V_BP         = DEF_V_BP,
    parameter int CLK_DIV      = DEF_CLK_DIV,
    parameter int COLOR_W      = DEF_COLOR_W,
    parameter bit HS_POL       = 1'b0,
    parameter bit VS_POL       = 1'b0,
    parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
    input  logic               reloj_nexys,
    input  logic               reset_total,
    input  logic [COLOR_W-1:0] color_in,
    output logic [10:0]        pixel_x,
    output logic [10:0]        pixel_y,
    output logic               pixel_tick,
    output logic               video_on,
    output logic               hsync,
    output logic               vsync,
    output logic               frame_start,
    output logic               line_start,
    output logic               blink,
    output logic [COLOR_W-1:0] color_salida
);

    localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FRAME_W-1:0] FRAME_MAX = FRAME_W'(BLINK_FRAMES - 1);

    logic [10:0] h_cnt;
    logic [10:0] v_cnt;
    logic        h_last;
    logic        v_last;
    logic        video_raw;
    logic        hsync_raw;
    logic        vsync_raw;
    logic        line_wrap;
    logic        frame_wrap;

    logic [COLOR_W-1:0] color_next;
    logic [COLOR_W-1:0] color_reg;
    logic               video_reg;
    logic               hsync_reg;
    logic               vsync_reg;
    logic               line_start_reg;
    logic               frame_start_reg;
    logic               blink_reg;
    logic [FRAME_W-1:0] frame_cnt_reg;

    vga_sync_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .CLK_DIV  (CLK_DIV)
    ) u_sync (
        .reloj_nexys (reloj_nexys),
        .reset_total (reset_total),
        .pixel_tick  (pixel_tick),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .h_last      (h_last),
        .v_last      (v_last),
        .video_raw   (video_raw),
        .hsync_raw   (hsync_raw),
        .vsync_raw   (vsync_raw)
    );

    assign pixel_x    = h_cnt;
    assign pixel_y    = v_cnt;
    assign line_wrap  = pixel_tick && h_last;
    assign frame_wrap = line_wrap && v_last;

`ifdef VGA_BORDER_EN
    localparam logic [10:0] H_ACT_LAST = 11'(H_ACTIVE - 1);
    localparam logic [10:0] V_ACT_LAST = 11'(V_ACTIVE - 1);

    logic on_border;
    assign on_border = (h_cnt == 11'd0) || (h_cnt == H_ACT_LAST) ||
                       (v_cnt == 11'd0) || (v_cnt == V_ACT_LAST);

    always_comb begin
        color_next = '0;
        if (video_raw) begin
            color_next = on_border ? '1 : color_in;
        end
    end
`else
    always_comb begin
        color_next = '0;
        if (video_raw) begin
            color_next = color_in;
        end
    end
`endif

    // Outputs capture the pixel the counters show at the tick, so they trail
    // pixel_x/pixel_y by exactly one pixel period.
    always_ff @(posedge reloj_nexys or negedge reset_total) begin
        if (!reset_total) begin
            video_reg <= 1'b0;
            hsync_reg <= ~HS_POL;
            vsync_reg <= ~VS_POL;
            color_reg <= '0;
        end else if (pixel_tick) begin
            video_reg <= video_raw;
            hsync_reg <= hsync_raw ? HS_POL : ~HS_POL;
            vsync_reg <= vsync_raw ? VS_POL : ~VS_POL;
            color_reg <= color_next;
        end
    end

    always_ff @(posedge reloj_nexys or negedge reset_total) begin
        if (!reset_total) begin
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
            frame_cnt_reg   <= '0;
            blink_reg       <= 1'b0;
        end else begin
            line_start_reg  <= line_wrap;
            frame_start_reg <= frame_wrap;
            if (frame_wrap) begin
                if (frame_cnt_reg == FRAME_MAX) begin
                    frame_cnt_reg <= '0;
                    blink_reg     <= ~blink_reg;
                end else begin
                    frame_cnt_reg <= frame_cnt_reg + 1'b1;
                end
            end
        end
    end

    assign video_on     = video_reg;
    assign hsync        = hsync_reg;
    assign vsync        = vsync_reg;
    assign color_salida = color_reg;
    assign line_start   = line_start_reg;
    assign frame_start  = frame_start_reg;
    assign blink        = blink_reg;

endmodule
